// File: rtl/alu_pkg.sv
// Shared definitions for the ALU accumulator sequencer: datapath width, command encoding, FSM states.
package alu_pkg;

    localparam int ALU_WIDTH = 4;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

endpackage

// File: rtl/alu_acc_sequencer.sv
// Accumulator sequencer in front of a combinational add/sub ALU.
// ADD/SUB: accept-to-done SETTLE_CYCLES+1 cycles; LOAD/CLEAR: done next cycle. Ready only in IDLE.
module alu_acc_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH         = ALU_WIDTH,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_s,
    input  logic [WIDTH-1:0] alu_q,
    input  logic             alu_c,
    output logic [WIDTH-1:0] acc,
    output logic             carry_flag,
    output logic             zero_flag,
    output logic             done
);

    state_t           r_state;
    logic [3:0]       r_cnt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_op_b;
    logic             r_op_s;
    logic             r_carry;
    logic             r_zero;
    logic             r_done;
    logic             r_ready;
    logic             w_accept;

    assign w_accept = cmd_valid && r_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_op_b  <= '0;
            r_op_s  <= 1'b0;
            r_carry <= 1'b0;
            r_zero  <= 1'b1;
            r_done  <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        case (cmd_op)
                            OP_ADD, OP_SUB: begin
                                r_op_b  <= cmd_data;
                                r_op_s  <= cmd_op[0];
                                r_cnt   <= 4'(SETTLE_CYCLES - 1);
                                r_state <= EXEC;
                                r_ready <= 1'b0;
                            end
                            OP_LOAD: begin
                                r_acc   <= cmd_data;
                                r_carry <= 1'b0;
                                r_zero  <= (cmd_data == '0);
                                r_done  <= 1'b1;
                            end
                            default: begin
                                r_acc   <= '0;
                                r_carry <= 1'b0;
                                r_zero  <= 1'b1;
                                r_done  <= 1'b1;
                            end
                        endcase
                    end
                end
                EXEC: begin
                    // Operands stay frozen here so the ALU output can settle.
                    if (r_cnt == 4'd0) begin
                        r_state <= WB;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                WB: begin
                    r_acc   <= alu_q;
                    r_carry <= alu_c;
                    r_zero  <= (alu_q == '0);
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready  = r_ready;
    assign alu_a      = r_acc;
    assign alu_b      = r_op_b;
    assign alu_s      = r_op_s;
    assign acc        = r_acc;
    assign carry_flag = r_carry;
    assign zero_flag  = r_zero;
    assign done       = r_done;

endmodule

// File: tb/tb_alu_acc_sequencer.sv
// Directed bench: two sequencer instances (SETTLE_CYCLES 1 and 3), each with a behavioural add/sub ALU.
module tb_alu_acc_sequencer;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    // SETTLE_CYCLES = 1 instance
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [3:0] cmd_data = 4'h0;
    logic [3:0] alu_a, alu_b, alu_q, acc;
    logic       alu_s, alu_c, carry_flag, zero_flag, done;
    logic [4:0] alu_sum;

    assign alu_sum = {1'b0, alu_a} + {1'b0, (alu_s ? ~alu_b : alu_b)} + {4'b0, alu_s};
    assign alu_q   = alu_sum[3:0];
    assign alu_c   = alu_sum[4];

    alu_acc_sequencer #(.WIDTH(4), .SETTLE_CYCLES(1)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_q(alu_q), .alu_c(alu_c),
        .acc(acc), .carry_flag(carry_flag), .zero_flag(zero_flag), .done(done)
    );

    // SETTLE_CYCLES = 3 instance
    logic       c3_valid = 1'b0;
    logic       c3_ready;
    logic [1:0] c3_op = 2'b00;
    logic [3:0] c3_data = 4'h0;
    logic [3:0] a3, b3, q3, acc3;
    logic       s3, c3, carry3, zero3, done3;
    logic [4:0] sum3;

    assign sum3 = {1'b0, a3} + {1'b0, (s3 ? ~b3 : b3)} + {4'b0, s3};
    assign q3   = sum3[3:0];
    assign c3   = sum3[4];

    alu_acc_sequencer #(.WIDTH(4), .SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst),
        .cmd_valid(c3_valid), .cmd_ready(c3_ready), .cmd_op(c3_op), .cmd_data(c3_data),
        .alu_a(a3), .alu_b(b3), .alu_s(s3), .alu_q(q3), .alu_c(c3),
        .acc(acc3), .carry_flag(carry3), .zero_flag(zero3), .done(done3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one command on the SETTLE=1 instance; return cycles from accept edge to done.
    task automatic run_cmd(input logic [1:0] op, input logic [3:0] data, output int lat);
        int guard;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        guard = 0;
        while (!cmd_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            if (op == OP_ADD || op == OP_SUB) check("ready_low_busy", cmd_ready, 0);
            @(negedge clk);
            lat++;
        end
        if (lat >= 20) check("done_timeout", 0, 1);
    endtask

    task automatic expect_state(input string tag, input logic [3:0] a, input logic c, input logic z);
        check({tag, "_acc"}, acc, a);
        check({tag, "_carry"}, carry_flag, c);
        check({tag, "_zero"}, zero_flag, z);
    endtask

    initial begin
        int lat;
        int seen;

        // Reset values
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        expect_state("rst", 4'h0, 1'b0, 1'b1);
        check("rst_ready", cmd_ready, 1);
        check("rst_done", done, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_alu_s", alu_s, 0);

        // LOAD 3, ADD 1
        run_cmd(OP_LOAD, 4'h3, lat);
        check("load_lat", lat, 0);
        check("alu_a_follows_acc", alu_a, 4'h3);
        run_cmd(OP_ADD, 4'h1, lat);
        check("add_lat", lat, 2);
        expect_state("add", 4'h4, 1'b0, 1'b0);

        // SUB without and with borrow
        run_cmd(OP_LOAD, 4'h4, lat);
        run_cmd(OP_SUB, 4'h2, lat);
        expect_state("sub_nb", 4'h2, 1'b1, 1'b0);
        check("sub_alu_s", alu_s, 1);
        run_cmd(OP_LOAD, 4'h3, lat);
        run_cmd(OP_SUB, 4'h5, lat);
        expect_state("sub_b", 4'he, 1'b0, 1'b0);

        // Wrap-around
        run_cmd(OP_LOAD, 4'hf, lat);
        run_cmd(OP_ADD, 4'h1, lat);
        expect_state("wrap", 4'h0, 1'b1, 1'b1);

        // LOAD then CLEAR back-to-back
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_LOAD; cmd_data = 4'h5;
        @(negedge clk);
        check("b2b_done1", done, 1);
        check("b2b_acc1", acc, 4'h5);
        cmd_op = OP_CLEAR; cmd_data = 4'h9;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("b2b_done2", done, 1);
        expect_state("b2b_clr", 4'h0, 1'b0, 1'b1);
        @(negedge clk);
        check("b2b_done_end", done, 0);

        // Second command held while an ADD executes
        run_cmd(OP_LOAD, 4'h2, lat);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_data = 4'h1;
        @(negedge clk);
        cmd_data = 4'h3;
        check("hold_exec_ready", cmd_ready, 0);
        @(negedge clk);
        check("hold_wb_done", done, 0);
        @(negedge clk);
        check("hold_first_done", done, 1);
        check("hold_first_acc", acc, 4'h3);
        check("hold_ready_idle", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("hold_second_taken", cmd_ready, 0);
        check("hold_no_double_done", done, 0);
        repeat (2) @(negedge clk);
        check("hold_second_done", done, 1);
        check("hold_second_acc", acc, 4'h6);

        // Asynchronous reset in the middle of EXEC (SETTLE=3 instance idle meanwhile)
        run_cmd(OP_LOAD, 4'h7, lat);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_data = 4'h1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("pre_rst_busy", cmd_ready, 0);
        #2 rst = 1'b1;
        #1;
        expect_state("async_rst", 4'h0, 1'b0, 1'b1);
        check("async_rst_ready", cmd_ready, 1);
        check("async_rst_alu_b", alu_b, 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("async_rst_no_done", seen, 0);
        check("async_rst_acc_hold", acc, 4'h0);

        // SETTLE_CYCLES = 3: LOAD 6, SUB 1
        @(negedge clk);
        c3_valid = 1'b1; c3_op = OP_LOAD; c3_data = 4'h6;
        @(negedge clk);
        check("s3_load_done", done3, 1);
        c3_op = OP_SUB; c3_data = 4'h1;
        @(negedge clk);
        c3_valid = 1'b0;
        lat = 0;
        while (!done3 && lat < 20) begin
            check("s3_ready_low", c3_ready, 0);
            @(negedge clk);
            lat++;
        end
        check("s3_lat", lat, 4);
        check("s3_acc", acc3, 4'h5);
        check("s3_carry", carry3, 1);
        check("s3_zero", zero3, 0);
        @(negedge clk);
        check("s3_done_pulse", done3, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
